// File: rtl/rand_draw_if.sv
// rand_draw_if: request/result handshake and upstream LFSR hookup for rand_draw
// master: requester/consumer/LFSR side (req_valid, req_range, res_ready, rand_in)
// slave : rand_draw side (req_ready, res_valid, res_value, res_tries, res_err, rand_en)
interface rand_draw_if;
   logic       req_valid;
   logic [8:0] req_range;
   logic       req_ready;
   logic       res_valid;
   logic       res_ready;
   logic [8:0] res_value;
   logic [3:0] res_tries;
   logic       res_err;
   logic [8:0] rand_in;
   logic       rand_en;
   modport master (
      output req_valid, req_range, res_ready, rand_in,
      input  req_ready, res_valid, res_value, res_tries, res_err, rand_en
   );
   modport slave (
      input  req_valid, req_range, res_ready, rand_in,
      output req_ready, res_valid, res_value, res_tries, res_err, rand_en
   );
endinterface

// File: rtl/rand_draw.sv
// rand_draw: uniform draw in 0..N-1 from an upstream 9-bit LFSR by masked rejection sampling
// clk, reset (async active-low); bus: rand_draw_if.slave carrying request, result and LFSR signals
module rand_draw #(
   parameter int MAX_TRIES = 15
) (
   input logic       clk,
   input logic       reset,
   rand_draw_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DRAW, CHECK, DONE} state_t;
   localparam logic [3:0] LAST = 4'(MAX_TRIES - 1);
   state_t     state_q, state_d;
   logic [8:0] n_q, n_d, mask_q, mask_d, val_q, val_d, cand;
   logic [3:0] tries_q, tries_d;
   logic       err_q, err_d, accept, hit;
   // smallest all-ones value covering n-1, i.e. (2^k >= n) - 1
   function automatic logic [8:0] mask_of(input logic [8:0] n);
      logic [8:0] m;
      m = n - 9'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      return m;
   endfunction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         mask_q  <= '0;
         val_q   <= '0;
         tries_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         mask_q  <= mask_d;
         val_q   <= val_d;
         tries_q <= tries_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      accept  = state_q == IDLE && bus.req_valid;
      cand    = bus.rand_in & mask_q;
      hit     = cand < n_q;
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = bus.req_valid ? (bus.req_range == '0 ? DONE : DRAW) : IDLE;
         DRAW:  state_d = CHECK;
         CHECK: state_d = (hit || tries_q == LAST) ? DONE : DRAW;
         DONE:  state_d = bus.res_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
      n_d     = accept ? bus.req_range : n_q;
      mask_d  = accept ? mask_of(bus.req_range) : mask_q;
      err_d   = accept ? bus.req_range == '0 : err_q;
      // a rejection on the last try lands exactly on MAX_TRIES, so one increment covers both cases
      tries_d = accept ? 4'd0 : (state_q == CHECK && !hit) ? tries_q + 4'd1 : tries_q;
      // cand < 2N always holds, so cand-N is a valid fallback in 0..N-1
      val_d   = accept ? 9'd0 : state_q == CHECK ? (hit ? cand : cand - n_q) : val_q;
   end
   always_comb begin
      bus.req_ready = state_q == IDLE;
      bus.rand_en   = state_q == DRAW;
      bus.res_valid = state_q == DONE;
      bus.res_value = val_q;
      bus.res_tries = tries_q;
      bus.res_err   = err_q;
   end
endmodule
